dut_req_arbiter: RTL
====================

DUT_REQ_ARBITER -- requirements
Module: dut_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: payload width per requester.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset; both are listed below.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  one-hot capture strobe; combinational.
REQ-009 out_valid  output  1  registered transaction valid toward the DUT port.
REQ-010 out_data  output  DATA_W  registered payload.
REQ-011 out_src  output  $clog2(NUM_REQ)  index of the requester that issued out_data.
REQ-012 out_ready  input  1  DUT accepts out_data.
REQ-013 busy  output  1  high when state is SEND.

Function
REQ-014 The FSM SHALL have two states: IDLE (out_valid=0) and SEND (out_valid=1).
REQ-015 A slot is "free" in IDLE, and in SEND when out_ready=1.
REQ-016 When the slot is free and any req_valid bit is set, the block SHALL select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-017 The block SHALL assert req_ready for the winner only, in the same cycle.
REQ-018 On the next edge, the block SHALL capture the winner's data into out_data and its index into out_src, and enter SEND.
REQ-019 Latency SHALL be one cycle: req_valid at edge t gives out_valid at edge t+1.
REQ-020 On a free slot with no req_valid set, the FSM SHALL go to (or stay in) IDLE, and req_ready SHALL be all zeros.
REQ-021 In SEND with out_ready=0, out_valid, out_data and out_src SHALL hold stable, and req_ready SHALL be all zeros.
REQ-022 On each out_valid&&out_ready edge, rr_ptr SHALL become (out_src+1) mod NUM_REQ.
REQ-023 A same-cycle re-grant SHALL search from the updated pointer value, giving full throughput of one transaction per cycle.
REQ-024 A requester whose req_valid is deasserted before its req_ready is asserted SHALL NOT be captured.
REQ-025 The block SHALL ignore req_data of non-winners.
REQ-026 Fairness: with all requesters continuously valid, each requester SHALL be granted exactly once per NUM_REQ consecutive grants.

Reset
REQ-027 While reset=0, the block SHALL force state=IDLE, out_valid=0, out_data=0, out_src=0, rr_ptr=0, and req_ready=0, asynchronously.
REQ-028 If reset asserts mid-SEND, the pending transaction SHALL be dropped without being presented again.
REQ-029 After reset release, the first grant SHALL search from requester 0.

Configuration
REQ-030 With macro ARB_STATS_EN defined, the block SHALL add output grant_cnt (NUM_REQ*16 bits): one 16-bit counter per requester.
REQ-031 Each grant_cnt counter SHALL increment on each capture for its requester, saturating at 0xFFFF, and reset to 0.
REQ-032 Without ARB_STATS_EN, the grant_cnt port and its counters SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-033 Single request: req_valid=4'b0100, data2=0x5A, out_ready=1 -> next cycle out_valid=1, out_data=0x5A, out_src=2; following grant search starts at 3.
REQ-034 All requesters valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with out_valid continuously high.
REQ-035 Backpressure: capture from requester 1 (data 0x33), out_ready=0 for 5 cycles -> out_data=0x33/out_src=1 stable, req_ready=0 throughout; out_ready=1 -> accepted, busy drops if no requests.
REQ-036 Wrap: rr_ptr=3, req_valid=4'b1001 -> requester 3 wins, then requester 0.
REQ-037 Reset mid-SEND: reset=0 while out_valid=1, out_ready=0 -> out_valid=0 immediately; after release, req_valid=4'b1111 -> out_src=0.
REQ-038 ARB_STATS_EN: 70000 grants to requester 0 -> grant_cnt[15:0]=0xFFFF, other counters unchanged.

Source files
------------

// File: rtl/dut_req_arbiter.sv
// Round-robin request arbiter feeding a single registered valid/ready output port.
// Optional per-requester grant counters are enabled with the ARB_STATS_EN macro.
module dut_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0]  out_src,
    input  logic                        out_ready,
    output logic                        busy
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [SRC_W-1:0]   r_out_src;
    logic [SRC_W-1:0]   r_rr_ptr;

    logic               w_hs;
    logic               w_free;
    logic [SRC_W-1:0]   w_ptr;
    logic               w_found;
    logic [SRC_W-1:0]   w_win;
    logic [DATA_W-1:0]  w_win_data;
    logic [NUM_REQ-1:0] w_onehot;

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base,
                                                    input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[SRC_W-1:0];
    endfunction

    assign w_hs   = (r_state == S_SEND) && out_ready;
    assign w_free = (r_state == S_IDLE) || out_ready;
    // Search starts from the pointer as it will be after this cycle's handshake.
    assign w_ptr  = w_hs ? wrap_idx(r_out_src, 1) : r_rr_ptr;

    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        w_onehot   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(w_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(w_ptr, k);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (SRC_W'(k) == w_win) w_win_data = req_data[k*DATA_W +: DATA_W];
        end
        w_onehot[w_win] = 1'b1;
    end

    assign req_ready = (reset && w_free && w_found) ? w_onehot : '0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign busy      = (r_state == S_SEND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_hs) r_rr_ptr <= wrap_idx(r_out_src, 1);
            if (w_free) begin
                if (w_found) begin
                    r_state     <= S_SEND;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_win_data;
                    r_out_src   <= w_win;
                end else begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) r_grant_cnt[k] <= '0;
        end else if (w_free && w_found && (r_grant_cnt[w_win] != '1)) begin
            r_grant_cnt[w_win] <= r_grant_cnt[w_win] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

endmodule
